// File: rtl/trace_stim_gen.sv
// Stimulus sequencer for the N-COBS encoder CSR port: it replays a loadable sample
// table in bursts, started either periodically or by a one-shot trigger, and honours stall backpressure.
module trace_stim_gen #(
    parameter int DATA_W        = 32,
    parameter int NUM_SAMPLES   = 4,
    parameter int BURST_LEN     = 8,
    parameter int PREEMPT_AT    = 7,
    parameter int PERIOD        = 2**25,
    parameter int LEVEL_W       = 2,
    parameter int IDLE_LEVEL    = 2,
    parameter int ACTIVE_LEVEL  = 1,
    parameter int PREEMPT_LEVEL = 0,
    localparam int IDX_W        = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               periodic_i,
    input  logic               start_i,
    input  logic               stall_i,
    input  logic               tbl_we_i,
    input  logic [IDX_W-1:0]   tbl_addr_i,
    input  logic [DATA_W-1:0]  tbl_wdata_i,
    output logic               csr_enable,
    output logic [DATA_W-1:0]  rs1_data,
    output logic [LEVEL_W-1:0] level,
    output logic               busy_o,
    output logic               done_o,
    output logic               led_o
);
    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam bit PRE_EN = (PREEMPT_AT < BURST_LEN);
    localparam logic [BEAT_W-1:0]  PRE_BEAT  = BEAT_W'(PREEMPT_AT);
    localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_SAMPLES - 1);
    localparam logic [LEVEL_W-1:0] LV_IDLE   = LEVEL_W'(IDLE_LEVEL);
    localparam logic [LEVEL_W-1:0] LV_ACT    = LEVEL_W'(ACTIVE_LEVEL);
    localparam logic [LEVEL_W-1:0] LV_PRE    = LEVEL_W'(PREEMPT_LEVEL);

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    state_t state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [BEAT_W-1:0]  beat, beat_n, issue_beat;
    logic [IDX_W-1:0]   idx, idx_n, issue_idx;
    logic               issue, trigger;
    logic               csr_n, busy_n, done_n, led_n;
    logic [DATA_W-1:0]  data_n;
    logic [LEVEL_W-1:0] level_n;
    logic [DATA_W-1:0]  tbl [NUM_SAMPLES];

    assign trigger = periodic_i ? (cnt == CNT_LAST) : start_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state      <= IDLE;
            cnt        <= '0;
            beat       <= '0;
            idx        <= '0;
            csr_enable <= 1'b0;
            rs1_data   <= '0;
            level      <= LV_IDLE;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            led_o      <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            beat       <= beat_n;
            idx        <= idx_n;
            csr_enable <= csr_n;
            rs1_data   <= data_n;
            level      <= level_n;
            busy_o     <= busy_n;
            done_o     <= done_n;
            led_o      <= led_n;
        end
    end

    // The table is read combinationally below, so a same-cycle write is seen only by later beats.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_SAMPLES; i++) tbl[i] <= '0;
        end else if (tbl_we_i && (int'(tbl_addr_i) < NUM_SAMPLES)) begin
            tbl[tbl_addr_i] <= tbl_wdata_i;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        beat_n     = beat;
        idx_n      = idx;
        csr_n      = 1'b0;
        data_n     = rs1_data;
        level_n    = level;
        busy_n     = busy_o;
        done_n     = 1'b0;
        led_n      = led_o;
        issue      = 1'b0;
        issue_beat = beat;
        issue_idx  = idx;
        case (state)
            IDLE: begin
                level_n = LV_IDLE;
                busy_n  = 1'b0;
                cnt_n   = periodic_i ? cnt + CNT_W'(1) : '0;
                if (trigger) begin
                    // Beat 0 is issued on the trigger edge so it shows up the very next cycle.
                    state_n    = BURST;
                    cnt_n      = '0;
                    led_n      = ~led_o;
                    busy_n     = 1'b1;
                    beat_n     = '0;
                    idx_n      = '0;
                    issue      = ~stall_i;
                    issue_beat = '0;
                    issue_idx  = '0;
                end
            end
            BURST: begin
                busy_n = 1'b1;
                if (beat == LAST_BEAT) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    level_n = LV_ACT;
                end else begin
                    issue = ~stall_i;
                end
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                level_n = LV_IDLE;
                cnt_n   = '0;
            end
            default: state_n = IDLE;
        endcase
        if (issue) begin
            csr_n   = 1'b1;
            data_n  = tbl[issue_idx];
            level_n = (PRE_EN && issue_beat == PRE_BEAT) ? LV_PRE : LV_ACT;
            beat_n  = issue_beat + BEAT_W'(1);
            idx_n   = (issue_idx == IDX_LAST) ? '0 : issue_idx + IDX_W'(1);
        end
    end
endmodule
